debug_display: RTL and testbench

Parametrised debug probe viewer that drives the board's seven-segment displays from a set of CPU observation buses. It selects one of CHANNELS probe words by switch, by automatic round-robin scan, or from a frozen snapshot. It registers the selected word and decodes it into active-low hex digits. It sits at the top level between the CPU debug outputs and the HEX pins, and replaces the fixed combinational case-mux-plus-decoder arrangement.

---
 rtl/debug_display.sv | 165 ++++++++++++++++
 tb/tb_debug_display.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_display.sv
// Debug probe viewer: selects one of CHANNELS probe words (manual, auto-scan or freeze),
// registers it and decodes it to active-low hex digits. Build option: LEADING_ZERO_BLANK_EN.
module debug_display #(
   parameter int CHANNELS = 8,
   parameter int WIDTH    = 32,
   parameter int DIGITS   = 8,
   parameter int SCAN_DIV = 50000000,
   localparam int CSEL    = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
   input  logic                  iClock,
   input  logic                  iReset,
   input  logic [CHANNELS*WIDTH-1:0] iProbes,
   input  logic [CSEL-1:0]       iSel,
   input  logic [1:0]            iMode,
   input  logic                  iCapture,
   output logic [CSEL-1:0]       oChannel,
   output logic [4*DIGITS-1:0]   oValue,
   output logic [7*DIGITS-1:0]   oSeg,
   output logic                  oFrozen
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CSEL-1:0]  LAST_CHAN   = CSEL'(CHANNELS - 1);
   localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(SCAN_DIV - 1);
   localparam logic [1:0]       MODE_AUTO   = 2'd1;
   localparam logic [1:0]       MODE_FREEZE = 2'd2;

   if (CHANNELS < 2) begin : g_bad_channels
      $error("debug_display: CHANNELS must be >= 2");
   end
   if (WIDTH > 4 * DIGITS) begin : g_bad_width
      $error("debug_display: WIDTH must be <= 4*DIGITS");
   end
   if (SCAN_DIV < 1) begin : g_bad_scan_div
      $error("debug_display: SCAN_DIV must be >= 1");
   end

   typedef enum logic [1:0] {
      VIEW_MANUAL,
      VIEW_SCAN,
      VIEW_FREEZE
   } view_t;

   function automatic logic [6:0] hex7(input logic [3:0] nib);
      logic [6:0] pat;
      case (nib)
         4'h0: pat = 7'h40;
         4'h1: pat = 7'h79;
         4'h2: pat = 7'h24;
         4'h3: pat = 7'h30;
         4'h4: pat = 7'h19;
         4'h5: pat = 7'h12;
         4'h6: pat = 7'h02;
         4'h7: pat = 7'h78;
         4'h8: pat = 7'h00;
         4'h9: pat = 7'h10;
         4'hA: pat = 7'h08;
         4'hB: pat = 7'h03;
         4'hC: pat = 7'h46;
         4'hD: pat = 7'h21;
         4'hE: pat = 7'h06;
         default: pat = 7'h0E;
      endcase
      return pat;
   endfunction

   logic [1:0]            mode_q;
   logic                  cap_q;
   logic [CNT_W-1:0]      scan_cnt;
   logic [CSEL-1:0]       chan_q;
   logic [4*DIGITS-1:0]   value_q;
   logic [7*DIGITS-1:0]   seg_q;
   logic                  frozen_q;

   view_t                 view;
   logic [CSEL-1:0]       sel_clamped;
   logic [CSEL-1:0]       chan_next;
   logic [CNT_W-1:0]      cnt_next;
   logic                  load;
   logic [WIDTH-1:0]      probe_word;
   logic [4*DIGITS-1:0]   value_next;
   logic [7*DIGITS-1:0]   seg_next;
`ifdef LEADING_ZERO_BLANK_EN
   logic                  lead_zero;
`endif

   // Channel/counter next-state. The chosen channel feeds the probe mux directly so
   // oValue and oChannel always move together, including on a scan advance.
   always_comb begin
      sel_clamped = (iSel > LAST_CHAN) ? LAST_CHAN : iSel;
      case (iMode)
         MODE_AUTO:   view = VIEW_SCAN;
         MODE_FREEZE: view = VIEW_FREEZE;
         default:     view = VIEW_MANUAL;
      endcase
      chan_next = chan_q;
      cnt_next  = '0;
      load      = 1'b1;
      case (view)
         VIEW_SCAN: begin
            if (mode_q == MODE_AUTO) begin
               if (scan_cnt == LAST_CNT) begin
                  chan_next = (chan_q == LAST_CHAN) ? '0 : chan_q + 1'b1;
               end else begin
                  cnt_next = scan_cnt + 1'b1;
               end
            end
         end
         VIEW_FREEZE: begin
            load = (mode_q != MODE_FREEZE) | (iCapture & ~cap_q);
            if (load) chan_next = sel_clamped;
         end
         default: chan_next = sel_clamped;
      endcase
      probe_word = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (chan_next == CSEL'(k)) probe_word = iProbes[k*WIDTH +: WIDTH];
      end
      value_next = '0;
      value_next[WIDTH-1:0] = probe_word;
   end

   // Segment decode runs from the registered word, adding the second pipeline stage.
   always_comb begin
      seg_next = '1;
`ifdef LEADING_ZERO_BLANK_EN
      lead_zero = 1'b1;
`endif
      for (int d = DIGITS - 1; d >= 0; d--) begin
`ifdef LEADING_ZERO_BLANK_EN
         lead_zero = lead_zero & (value_q[4*d +: 4] == 4'h0);
         if (lead_zero && d != 0) seg_next[7*d +: 7] = 7'h7F;
         else                     seg_next[7*d +: 7] = hex7(value_q[4*d +: 4]);
`else
         seg_next[7*d +: 7] = hex7(value_q[4*d +: 4]);
`endif
      end
   end

   always_ff @(posedge iClock) begin
      if (!iReset) begin
         mode_q   <= '0;
         cap_q    <= 1'b0;
         scan_cnt <= '0;
         chan_q   <= '0;
         value_q  <= '0;
         frozen_q <= 1'b0;
         seg_q    <= '1;
      end else begin
         mode_q   <= iMode;
         cap_q    <= iCapture;
         scan_cnt <= cnt_next;
         chan_q   <= chan_next;
         frozen_q <= (iMode == MODE_FREEZE);
         if (load) value_q <= value_next;
         seg_q    <= seg_next;
      end
   end

   assign oChannel = chan_q;
   assign oValue   = value_q;
   assign oSeg     = seg_q;
   assign oFrozen  = frozen_q;

endmodule

// File: tb/tb_debug_display.sv
// Bench for debug_display: an 8-channel/SCAN_DIV=4 instance and a 5-channel/SCAN_DIV=1 instance.
module tb_debug_display;

   localparam int CH = 8;
   localparam int W  = 32;
   localparam int D  = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [W-1:0]    pr [CH];
   logic [CH*W-1:0] probes;
   logic [2:0]      sel;
   logic [1:0]      mode;
   logic            cap;
   logic [2:0]      chan;
   logic [31:0]     value;
   logic [55:0]     seg;
   logic            frozen;

   logic [W-1:0]    pr5 [5];
   logic [5*W-1:0]  probes5;
   logic [2:0]      sel5;
   logic [1:0]      mode5;
   logic            cap5;
   logic [2:0]      chan5;
   logic [31:0]     value5;
   logic [55:0]     seg5;
   logic            frozen5;

   always_comb begin
      for (int k = 0; k < CH; k++) probes[k*W +: W] = pr[k];
      for (int k = 0; k < 5; k++) probes5[k*W +: W] = pr5[k];
   end

   debug_display #(.CHANNELS(CH), .WIDTH(W), .DIGITS(D), .SCAN_DIV(4)) dut (
      .iClock(clk), .iReset(rst_n), .iProbes(probes), .iSel(sel), .iMode(mode),
      .iCapture(cap), .oChannel(chan), .oValue(value), .oSeg(seg), .oFrozen(frozen)
   );

   debug_display #(.CHANNELS(5), .WIDTH(W), .DIGITS(D), .SCAN_DIV(1)) dut5 (
      .iClock(clk), .iReset(rst_n), .iProbes(probes5), .iSel(sel5), .iMode(mode5),
      .iCapture(cap5), .oChannel(chan5), .oValue(value5), .oSeg(seg5), .oFrozen(frozen5)
   );

   int n_cmp = 0;
   int n_err = 0;
   logic [W-1:0] exp_q[$];

   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] t [16];
      t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      return t[n];
   endfunction

   function automatic logic [55:0] seg_of(input logic [31:0] v);
      logic [55:0] s;
      for (int d = 0; d < 8; d++) begin
         s[7*d +: 7] = hex7(v[4*d +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
         if (d > 0 && (v >> (4*d)) == 32'h0) s[7*d +: 7] = 7'h7F;
`endif
      end
      return s;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_probes();
      for (int k = 0; k < CH; k++) pr[k] = $urandom;
   endtask

   task automatic test_reset();
      logic [55:0] blank_all;
      blank_all = '1;
      rst_n = 1'b0; mode = 2'd0; sel = 3'd0; cap = 1'b0;
      mode5 = 2'd0; sel5 = 3'd0; cap5 = 1'b0;
      for (int k = 0; k < CH; k++) pr[k] = '0;
      for (int k = 0; k < 5; k++) pr5[k] = '0;
      tick(); tick();
      n_cmp++; if (seg !== blank_all) begin n_err++; $display("FAIL reset_seg got %h want %h", seg, blank_all); end
      n_cmp++; if (value !== 32'h0) begin n_err++; $display("FAIL reset_value got %h want 0", value); end
      n_cmp++; if (chan !== 3'd0) begin n_err++; $display("FAIL reset_chan got %0d want 0", chan); end
      n_cmp++; if (frozen !== 1'b0) begin n_err++; $display("FAIL reset_frozen got %b want 0", frozen); end
      n_cmp++; if (seg5 !== blank_all) begin n_err++; $display("FAIL reset_seg5 got %h want %h", seg5, blank_all); end
      rst_n = 1'b1;
      tick(); tick();
      n_cmp++; if (seg !== seg_of(32'h0)) begin n_err++; $display("FAIL zero_seg got %h want %h", seg, seg_of(32'h0)); end
   endtask

   task automatic test_manual();
      logic [W-1:0] e, prev;
      logic [55:0] want;
      logic [2:0] s;
      mode = 2'd0; sel = 3'd3; pr[3] = 32'h1234ABCD;
      exp_q.push_back(pr[3]);
      tick();
      e = exp_q.pop_front();
      n_cmp++; if (value !== e) begin n_err++; $display("FAIL manual_value got %h want %h", value, e); end
      n_cmp++; if (chan !== 3'd3) begin n_err++; $display("FAIL manual_chan got %0d want 3", chan); end
      tick();
      want = {7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21};
      n_cmp++; if (seg !== want) begin n_err++; $display("FAIL manual_seg got %h want %h", seg, want); end
      prev = e;
      for (int i = 0; i < 10; i++) begin
         rand_probes();
         s = 3'($urandom_range(0, 7));
         sel = s;
         exp_q.push_back(pr[s]);
         tick();
         e = exp_q.pop_front();
         n_cmp++; if (value !== e) begin n_err++; $display("FAIL rand_value[%0d] got %h want %h", i, value, e); end
         n_cmp++; if (chan !== s) begin n_err++; $display("FAIL rand_chan[%0d] got %0d want %0d", i, chan, s); end
         n_cmp++; if (seg !== seg_of(prev)) begin n_err++; $display("FAIL rand_seg[%0d] got %h want %h", i, seg, seg_of(prev)); end
         prev = e;
      end
   endtask

   task automatic test_auto_scan();
      logic [W-1:0] e;
      logic [2:0] ec;
      mode = 2'd0; sel = 3'd6;
      tick();
      mode = 2'd1;
      for (int i = 0; i < 16; i++) begin
         rand_probes();
         ec = 3'((6 + i / 4) % 8);
         exp_q.push_back(pr[ec]);
         tick();
         e = exp_q.pop_front();
         n_cmp++; if (chan !== ec) begin n_err++; $display("FAIL scan_chan[%0d] got %0d want %0d", i, chan, ec); end
         n_cmp++; if (value !== e) begin n_err++; $display("FAIL scan_value[%0d] got %h want %h", i, value, e); end
      end
      // terminal count coincides with the switch back to manual
      mode = 2'd0; sel = 3'd1; rand_probes();
      exp_q.push_back(pr[1]);
      tick();
      e = exp_q.pop_front();
      n_cmp++; if (chan !== 3'd1) begin n_err++; $display("FAIL scan_exit_chan got %0d want 1", chan); end
      n_cmp++; if (value !== e) begin n_err++; $display("FAIL scan_exit_value got %h want %h", value, e); end
      mode = 2'd1;
      for (int i = 0; i < 5; i++) begin
         ec = (i < 4) ? 3'd1 : 3'd2;
         tick();
         n_cmp++; if (chan !== ec) begin n_err++; $display("FAIL rescan_chan[%0d] got %0d want %0d", i, chan, ec); end
      end
   endtask

   task automatic test_freeze();
      logic [W-1:0] e;
      mode = 2'd0; sel = 3'd0; cap = 1'b0;
      tick();
      mode = 2'd2; sel = 3'd2; pr[2] = $urandom;
      exp_q.push_back(pr[2]);
      tick();
      e = exp_q.pop_front();
      n_cmp++; if (value !== e) begin n_err++; $display("FAIL freeze_entry got %h want %h", value, e); end
      n_cmp++; if (frozen !== 1'b1) begin n_err++; $display("FAIL freeze_flag got %b want 1", frozen); end
      for (int i = 0; i < 4; i++) begin
         pr[2] = $urandom;
         tick();
         n_cmp++; if (value !== e) begin n_err++; $display("FAIL freeze_hold[%0d] got %h want %h", i, value, e); end
      end
      cap = 1'b1; pr[2] = $urandom;
      exp_q.push_back(pr[2]);
      tick();
      e = exp_q.pop_front();
      n_cmp++; if (value !== e) begin n_err++; $display("FAIL capture got %h want %h", value, e); end
      for (int i = 0; i < 4; i++) begin
         cap = (i < 3);
         pr[2] = ~e ^ $urandom;
         tick();
         n_cmp++; if (value !== e) begin n_err++; $display("FAIL cap_held[%0d] got %h want %h", i, value, e); end
      end
      cap = 1'b1; sel = 3'd5; rand_probes();
      exp_q.push_back(pr[5]);
      tick();
      e = exp_q.pop_front();
      n_cmp++; if (chan !== 3'd5) begin n_err++; $display("FAIL recap_chan got %0d want 5", chan); end
      n_cmp++; if (value !== e) begin n_err++; $display("FAIL recap_value got %h want %h", value, e); end
      // freeze entry together with a capture edge
      cap = 1'b0; mode = 2'd0;
      tick();
      mode = 2'd2; cap = 1'b1; sel = 3'd4; rand_probes();
      exp_q.push_back(pr[4]);
      tick();
      e = exp_q.pop_front();
      pr[4] = ~e;
      tick();
      n_cmp++; if (value !== e) begin n_err++; $display("FAIL entry_cap got %h want %h", value, e); end
      mode = 2'd0; cap = 1'b0;
      tick();
      n_cmp++; if (frozen !== 1'b0) begin n_err++; $display("FAIL unfreeze got %b want 0", frozen); end
   endtask

   task automatic test_reset_mid_freeze();
      logic [W-1:0] e;
      mode = 2'd2; sel = 3'd3; cap = 1'b0; pr[3] = 32'hCAFE0001;
      tick();
      pr[3] = 32'h0BAD0002;
      rst_n = 1'b0;
      tick();
      n_cmp++; if (value !== 32'h0) begin n_err++; $display("FAIL midrst_value got %h want 0", value); end
      n_cmp++; if (frozen !== 1'b0) begin n_err++; $display("FAIL midrst_frozen got %b want 0", frozen); end
      rst_n = 1'b1;
      exp_q.push_back(pr[3]);
      tick();
      e = exp_q.pop_front();
      n_cmp++; if (value !== e) begin n_err++; $display("FAIL midrst_reentry got %h want %h", value, e); end
      n_cmp++; if (frozen !== 1'b1) begin n_err++; $display("FAIL midrst_refreeze got %b want 1", frozen); end
      mode = 2'd0;
      tick();
   endtask

   task automatic test_clamp_and_fast_scan();
      logic [W-1:0] e;
      logic [2:0] ec;
      for (int k = 0; k < 5; k++) pr5[k] = $urandom;
      mode5 = 2'd0; sel5 = 3'd7;
      exp_q.push_back(pr5[4]);
      tick();
      e = exp_q.pop_front();
      n_cmp++; if (chan5 !== 3'd4) begin n_err++; $display("FAIL clamp_chan got %0d want 4", chan5); end
      n_cmp++; if (value5 !== e) begin n_err++; $display("FAIL clamp_value got %h want %h", value5, e); end
      sel5 = 3'd2;
      tick();
      n_cmp++; if (chan5 !== 3'd2) begin n_err++; $display("FAIL noclamp_chan got %0d want 2", chan5); end
      sel5 = 3'd3;
      tick();
      mode5 = 2'd1;
      for (int i = 0; i < 7; i++) begin
         for (int k = 0; k < 5; k++) pr5[k] = $urandom;
         ec = 3'((3 + i) % 5);
         exp_q.push_back(pr5[ec]);
         tick();
         e = exp_q.pop_front();
         n_cmp++; if (chan5 !== ec) begin n_err++; $display("FAIL fast_chan[%0d] got %0d want %0d", i, chan5, ec); end
         n_cmp++; if (value5 !== e) begin n_err++; $display("FAIL fast_value[%0d] got %h want %h", i, value5, e); end
      end
      mode5 = 2'd0;
   endtask

   task automatic test_zero_blank();
      logic [55:0] want;
      mode = 2'd0; sel = 3'd0; cap = 1'b0; pr[0] = 32'h00000A50;
      tick(); tick();
`ifdef LEADING_ZERO_BLANK_EN
      want = {{5{7'h7F}}, 7'h08, 7'h12, 7'h40};
`else
      want = {{5{7'h40}}, 7'h08, 7'h12, 7'h40};
`endif
      n_cmp++; if (value !== 32'h00000A50) begin n_err++; $display("FAIL blank_value got %h want 00000a50", value); end
      n_cmp++; if (seg !== want) begin n_err++; $display("FAIL blank_seg got %h want %h", seg, want); end
      pr[0] = 32'h0;
      tick(); tick();
`ifdef LEADING_ZERO_BLANK_EN
      want = {{7{7'h7F}}, 7'h40};
`else
      want = {8{7'h40}};
`endif
      n_cmp++; if (seg !== want) begin n_err++; $display("FAIL blank_zero got %h want %h", seg, want); end
      pr[0] = 32'h80000000;
      tick(); tick();
      want = {7'h00, {7{7'h40}}};
      n_cmp++; if (seg !== want) begin n_err++; $display("FAIL blank_msb got %h want %h", seg, want); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not finish, %0d compared", n_cmp);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_manual();
      test_auto_scan();
      test_freeze();
      test_reset_mid_freeze();
      test_clamp_and_fast_scan();
      test_zero_blank();
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_leftover got %0d entries want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
